// File: rtl/dual_lane_rr_arbiter_pkg.sv
// Shared types and helpers for the dual-lane round-robin arbiter.
package dual_lane_rr_arbiter_pkg;

    // Per-lane ownership state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lane_state_t;

    localparam int NUM_LANES = 2;

    // Width of the round-robin pointer; never narrower than one bit
    function automatic int ptr_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/first_two_set_bits.sv
// Combinational finder for the lowest and second-lowest set bits of a vector,
// each returned as a one-hot vector (zero when that bit does not exist).
module first_two_set_bits #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] first_o,
    output logic [WIDTH-1:0] second_o
);

    logic found_first;
    logic found_second;

    // Scan from LSB, marking the first two set bits encountered
    always_comb begin
        first_o      = '0;
        second_o     = '0;
        found_first  = 1'b0;
        found_second = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                if (!found_first) begin
                    first_o[i]  = 1'b1;
                    found_first = 1'b1;
                end else if (!found_second) begin
                    second_o[i]  = 1'b1;
                    found_second = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dual_lane_rr_arbiter.sv
// Round-robin arbiter sharing two resource lanes among WIDTH requesters,
// issuing up to two new grants per cycle. A lane is held until its done pulse.
module dual_lane_rr_arbiter
    import dual_lane_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [WIDTH-1:0]            req_i,
    input  logic [NUM_LANES-1:0]        done_i,
    output logic [WIDTH-1:0]            gnt0_o,
    output logic [WIDTH-1:0]            gnt1_o,
    output logic [NUM_LANES-1:0]        busy_o,
    output logic [ptr_width(WIDTH)-1:0] ptr_o
);

    localparam int PW = ptr_width(WIDTH);

    lane_state_t      state_q  [NUM_LANES];
    lane_state_t      state_d  [NUM_LANES];
    logic [WIDTH-1:0] owner_q  [NUM_LANES];
    logic [WIDTH-1:0] owner_d  [NUM_LANES];
    logic [WIDTH-1:0] lane_gnt [NUM_LANES];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [PW-1:0]    last_idx;

    logic [WIDTH-1:0] eligible;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] first_rot;
    logic [WIDTH-1:0] second_rot;
    logic [WIDTH-1:0] cand1;
    logic [WIDTH-1:0] cand2;
    logic [WIDTH-1:0] last_gnt;

    // Owner registers are zero whenever a lane is idle, so masking by them
    // excludes exactly the current owners, including ones releasing this cycle.
    assign eligible = req_i & ~owner_q[0] & ~owner_q[1];

    // Rotate right by the pointer so the pointer position becomes bit 0
    assign rot = WIDTH'({eligible, eligible} >> ptr_q);

    first_two_set_bits #(
        .WIDTH(WIDTH)
    ) u_first_two (
        .vec     (rot),
        .first_o (first_rot),
        .second_o(second_rot)
    );

    // Rotate candidates back to absolute requester indices
    assign cand1 = WIDTH'(({first_rot, first_rot} << ptr_q) >> WIDTH);
    assign cand2 = WIDTH'(({second_rot, second_rot} << ptr_q) >> WIDTH);

    // Hand candidates to lanes that were idle at the start of the cycle
    always_comb begin
        lane_gnt[0] = '0;
        lane_gnt[1] = '0;
        last_gnt    = '0;
        if (state_q[0] == IDLE && state_q[1] == IDLE) begin
            lane_gnt[0] = cand1;
            lane_gnt[1] = cand2;
            last_gnt    = (|cand2) ? cand2 : cand1;
        end else if (state_q[0] == IDLE) begin
            lane_gnt[0] = cand1;
            last_gnt    = cand1;
        end else if (state_q[1] == IDLE) begin
            lane_gnt[1] = cand1;
            last_gnt    = cand1;
        end
    end

    // Advance the pointer just past the last granted candidate
    always_comb begin
        last_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (last_gnt[i]) begin
                last_idx = PW'(i);
            end
        end
        ptr_d = ptr_q;
        if (|last_gnt) begin
            ptr_d = (last_idx == PW'(WIDTH - 1)) ? '0 : last_idx + PW'(1);
        end
    end

    // Lane FSM next state: grants only into idle lanes, done only frees busy lanes
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            state_d[l] = state_q[l];
            owner_d[l] = owner_q[l];
            case (state_q[l])
                IDLE: begin
                    if (|lane_gnt[l]) begin
                        state_d[l] = BUSY;
                        owner_d[l] = lane_gnt[l];
                    end
                end
                BUSY: begin
                    if (done_i[l]) begin
                        state_d[l] = IDLE;
                        owner_d[l] = '0;
                    end
                end
                default: begin
                    state_d[l] = IDLE;
                    owner_d[l] = '0;
                end
            endcase
        end
    end

    // State, owner and pointer registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= IDLE;
                owner_q[l] <= '0;
            end
            ptr_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= state_d[l];
                owner_q[l] <= owner_d[l];
            end
            ptr_q <= ptr_d;
        end
    end

    assign gnt0_o    = (state_q[0] == BUSY) ? owner_q[0] : '0;
    assign gnt1_o    = (state_q[1] == BUSY) ? owner_q[1] : '0;
    assign busy_o[0] = (state_q[0] == BUSY);
    assign busy_o[1] = (state_q[1] == BUSY);
    assign ptr_o     = ptr_q;

endmodule

// File: tb/tb_dual_lane_rr_arbiter.sv
// Self-checking bench for dual_lane_rr_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based round-robin model.
module tb_dual_lane_rr_arbiter;

    localparam int W = 12;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  req;
    logic [1:0]    done;
    logic [W-1:0]  gnt0;
    logic [W-1:0]  gnt1;
    logic [1:0]    busy;
    logic [3:0]    ptr;

    int compared;
    int mismatched;

    // Model state: owner index per lane (-1 means idle) and pointer
    int mOwner [2];
    int mPtr;

    dual_lane_rr_arbiter #(
        .WIDTH(W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req),
        .done_i(done),
        .gnt0_o(gnt0),
        .gnt1_o(gnt1),
        .busy_o(busy),
        .ptr_o (ptr)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        mOwner[0] = -1;
        mOwner[1] = -1;
        mPtr      = 0;
    endtask

    // One clock edge of the arbiter described from its rules
    task automatic modelStep(input logic [W-1:0] r, input logic [1:0] d);
        int cand[$];
        int nOwner [2];
        bit wasIdle [2];
        int idx;
        int ci;
        int lastIdx;
        for (int l = 0; l < 2; l++) begin
            wasIdle[l] = (mOwner[l] < 0);
            nOwner[l]  = mOwner[l];
        end
        for (int k = 0; k < W; k++) begin
            idx = (mPtr + k) % W;
            if (r[idx[3:0]] && mOwner[0] != idx && mOwner[1] != idx && cand.size() < 2) begin
                cand.push_back(idx);
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (!wasIdle[l] && d[l]) nOwner[l] = -1;
        end
        ci = 0;
        lastIdx = -1;
        for (int l = 0; l < 2; l++) begin
            if (wasIdle[l] && ci < cand.size()) begin
                nOwner[l] = cand[ci];
                lastIdx   = cand[ci];
                ci++;
            end
        end
        mOwner[0] = nOwner[0];
        mOwner[1] = nOwner[1];
        if (lastIdx >= 0) mPtr = (lastIdx + 1) % W;
    endtask

    function automatic logic [W-1:0] ownerVec(input int o);
        logic [W-1:0] v;
        v = '0;
        if (o >= 0) v[o[3:0]] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string tag);
        cmp({tag, ".gnt0"}, 32'(gnt0), 32'(ownerVec(mOwner[0])));
        cmp({tag, ".gnt1"}, 32'(gnt1), 32'(ownerVec(mOwner[1])));
        cmp({tag, ".busy"}, 32'(busy), {30'b0, mOwner[1] >= 0, mOwner[0] >= 0});
        cmp({tag, ".ptr"},  32'(ptr),  32'(mPtr));
    endtask

    // Drive inputs on the falling edge, step the model at the rising edge, sample 1 later
    task automatic applyStimulus(input logic [W-1:0] r, input logic [1:0] d, input string tag);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        modelStep(r, d);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        modelReset();
        rst_n = 1'b0;
        req   = '0;
        done  = 2'b00;

        #12;
        cmp("reset.gnt0", 32'(gnt0), 32'h0);
        cmp("reset.gnt1", 32'(gnt1), 32'h0);
        cmp("reset.busy", 32'(busy), 32'h0);
        cmp("reset.ptr",  32'(ptr),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic dual grant
        applyStimulus(12'b0010_1100_1101, 2'b00, "dual");
        cmp("dual.gnt0", 32'(gnt0), 32'h001);
        cmp("dual.gnt1", 32'(gnt1), 32'h004);
        cmp("dual.busy", 32'(busy), 32'h3);
        cmp("dual.ptr",  32'(ptr),  32'h3);

        // Release lane 0, then re-grant one cycle later
        applyStimulus(12'b0010_1100_1101, 2'b01, "release");
        cmp("release.busy", 32'(busy), 32'h2);
        applyStimulus(12'b0010_1100_1101, 2'b00, "regrant");
        cmp("regrant.gnt0", 32'(gnt0), 32'h008);
        cmp("regrant.gnt1", 32'(gnt1), 32'h004);
        cmp("regrant.ptr",  32'(ptr),  32'h4);

        // Wrap-around from pointer 4
        applyStimulus(12'h000, 2'b11, "free_both");
        applyStimulus(12'b0000_0000_0011, 2'b00, "wrap");
        cmp("wrap.gnt0", 32'(gnt0), 32'h001);
        cmp("wrap.gnt1", 32'(gnt1), 32'h002);
        cmp("wrap.ptr",  32'(ptr),  32'h2);

        // Bring pointer to 0, then grant from the top indices
        applyStimulus(12'h000, 2'b11, "free_wrap");
        applyStimulus(12'h800, 2'b00, "top_single");
        cmp("top_single.ptr", 32'(ptr), 32'h0);
        applyStimulus(12'h000, 2'b01, "free_top");
        applyStimulus(12'hC00, 2'b00, "top_pair");
        cmp("top_pair.gnt0", 32'(gnt0), 32'h400);
        cmp("top_pair.gnt1", 32'(gnt1), 32'h800);
        cmp("top_pair.ptr",  32'(ptr),  32'h0);

        // Single request with both lanes idle, then hold with no requests
        applyStimulus(12'h000, 2'b11, "free_pair");
        applyStimulus(12'h008, 2'b00, "single");
        cmp("single.gnt0", 32'(gnt0), 32'h008);
        cmp("single.gnt1", 32'(gnt1), 32'h000);
        cmp("single.busy", 32'(busy), 32'h1);
        cmp("single.ptr",  32'(ptr),  32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(12'h000, 2'b00, "hold");
            cmp("hold.gnt0", 32'(gnt0), 32'h008);
            cmp("hold.ptr",  32'(ptr),  32'h4);
        end

        // Fill lane 1, then reset asynchronously between edges
        applyStimulus(12'h030, 2'b00, "fill");
        cmp("fill.busy", 32'(busy), 32'h3);
        #3;
        rst_n = 1'b0;
        req   = '0;
        done  = 2'b00;
        #1;
        cmp("async.gnt0", 32'(gnt0), 32'h0);
        cmp("async.gnt1", 32'(gnt1), 32'h0);
        cmp("async.busy", 32'(busy), 32'h0);
        cmp("async.ptr",  32'(ptr),  32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(12'h000, 2'b11, "done_idle");
        applyStimulus(12'h000, 2'b11, "done_idle2");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] r;
            logic [1:0]   d;
            r = W'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            applyStimulus(r, d, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dual_lane_rr_arbiter.md
# dual_lane_rr_arbiter

Round-robin arbiter that shares two identical resource lanes among `WIDTH` requesters and can issue up to two new grants per cycle. Selection is done by rotating the eligible-request vector to the priority pointer and extracting its first and second set bits from LSB. The granted requester owns its lane until the lane signals completion. It sits between the request vector of the requesting agents and a pair of shared execution or port slots.

## Interface
- `WIDTH`, 12: number of requesters (≥2).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in WIDTH: level request per requester; held until granted.
- `done_i` in 2: per-lane release pulse; bit k releases lane k.
- `gnt0_o` out WIDTH: one-hot owner of lane 0; zero when lane 0 is idle.
- `gnt1_o` out WIDTH: one-hot owner of lane 1; zero when lane 1 is idle.
- `busy_o` out 2: lane k is BUSY.
- `ptr_o` out $clog2(WIDTH): current round-robin pointer.

## Operation
- Each lane runs a 2-state FSM, IDLE/BUSY, with a WIDTH-bit owner register.
  - IDLE→BUSY when the lane is assigned a candidate.
  - BUSY→IDLE when `done_i[k]`=1.
  - `done_i[k]` on an IDLE lane is ignored.
- Eligibility: `eligible = req_i & ~owner0 & ~owner1`. Owners of BUSY lanes are excluded even when being released this cycle.
- Candidate selection:
  - `rot = eligible` rotated right by `ptr`.
  - c1 and c2 are the first and second set bits of `rot` from LSB.
  - Both are rotated back to absolute index.
  - Fewer than two set bits yields zero for the missing candidates.
- Lane assignment uses lanes IDLE at the start of the cycle.
  - Both lanes IDLE: lane 0 gets c1, lane 1 gets c2.
  - Exactly one lane IDLE: that lane gets c1; c2 is discarded.
  - No lane IDLE: no grant.
- A lane freed by `done_i` this cycle cannot be re-granted in the same cycle. This gives a one-cycle idle bubble.
- Pointer update:
  - If any grant is issued, `ptr` becomes (absolute index of the last candidate granted in rotated order + 1) mod WIDTH. Wrap is from WIDTH-1 to 0.
  - If no grant is issued, `ptr` is unchanged.
- Dropping `req_i` while owning a lane does not release the lane; only `done_i` releases it.
- `gnt0_o`/`gnt1_o` equal the owner registers while BUSY and are forced to zero while IDLE.
- A requester never holds both lanes.

## Timing
- Reset, applied asynchronously:
  - Both lanes IDLE, owners 0.
  - `gnt0_o`=`gnt1_o`=0, `busy_o`=2'b00, `ptr_o`=0.
- Reset asserted mid-operation clears all grants immediately, without waiting for a clock edge.
- Latency: `req_i` sampled at edge t, grant visible after edge t (registered outputs, 1 cycle).
- Release: `done_i[k]` sampled at edge t clears the grant after edge t. Earliest re-grant of lane k is after edge t+1.
- Simultaneous `done_i`=2'b11 releases both lanes in the same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package contains:
  - `lane_state_t` enum {IDLE, BUSY}.
  - `NUM_LANES`=2.
  - Pointer width function or constant.
- One sub-module, `first_two_set_bits`: combinational, parameter WIDTH, outputs one-hot `first_o` and `second_o`. The arbiter instantiates it on the rotated vector.
- Rotate and unrotate logic stays in the top module.
- Estimated size: roughly 150–250 lines of RTL.

## Test plan
- Basic dual grant (WIDTH=12, after reset):
  - Stimulus: `req_i`=12'b0010_1100_1101, `done_i`=0.
  - After one edge: `gnt0_o`=12'b0000_0000_0001, `gnt1_o`=12'b0000_0000_0100, `busy_o`=2'b11, `ptr_o`=3.
- Release and rotation (continue with `req_i` unchanged):
  - Pulse `done_i`=2'b01 for one cycle: lane 0 IDLE after that edge.
  - After the next edge: `gnt0_o`=12'b0000_0000_1000, `ptr_o`=4, `gnt1_o` unchanged.
- Wrap-around:
  - Setup: `ptr_o`=4, both lanes IDLE.
  - Stimulus: `req_i`=12'b0000_0000_0011.
  - Response: `gnt0_o`=bit 0, `gnt1_o`=bit 1, `ptr_o`=2.
- Pointer wrap from top index:
  - Setup: `ptr_o`=0.
  - Stimulus: `req_i`=12'b1100_0000_0000.
  - Response: grants bits 10 and 11, `ptr_o`=0.
- Single request, both lanes idle:
  - Stimulus: `req_i`=12'b0000_0000_1000.
  - Response: only lane 0 granted (bit 3), `gnt1_o`=0, `busy_o`=2'b01, `ptr_o`=4.
  - With `req_i`=0 for several cycles: outputs unchanged.
- Async reset with both lanes BUSY:
  - Stimulus: pull `rst_ni` low between edges.
  - Response: `gnt0_o`, `gnt1_o`, `busy_o`, `ptr_o` go to 0 before the next edge.
  - After release with `done_i` held 1 on IDLE lanes: no effect.
